// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for single and indirect data-memory accesses,
// producing handshake strobes, address mux select, byte enables, trap PC select and stall.
module mem_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [2:0]       mem_op,
  input  logic [3:0]       addr_lo,
  input  logic             dmem_resp,
  output logic             mem_addr_mux_sel,
  output logic             ind_load,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [15:0]      dmem_byte_enable,
  output logic [1:0]       newpcmux_sel,
  output logic             trap_pc_load,
  output logic             stall,
  output logic             done,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [2:0] OP_STW = 3'b011, OP_STB = 3'b100, OP_LDI = 3'b101,
                         OP_STI = 3'b110, OP_TRAP = 3'b111;
  typedef enum logic [2:0] {IDLE, ACC1, IND, ACC2, DONE} state_t;
  state_t     state;
  logic [2:0] op;
  logic       is_mem, is_store, is_ind;
  assign is_mem   = valid_in && mem_op != 3'b000;
  assign is_store = op == OP_STW || op == OP_STB;
  assign is_ind   = op == OP_LDI || op == OP_STI;
  // op is latched on leaving IDLE so the frozen pipeline's inputs never matter mid-sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= 3'b000;
      stall_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      case (state)
        IDLE: if (is_mem) begin
          state <= ACC1;
          op    <= mem_op;
        end
        ACC1:    if (dmem_resp) state <= is_ind ? IND : DONE;
        IND:     state <= ACC2;
        ACC2:    if (dmem_resp) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    dmem_read        = (state == ACC1 && !is_store) || (state == ACC2 && op == OP_LDI);
    dmem_write       = (state == ACC1 && is_store) || (state == ACC2 && op == OP_STI);
    mem_addr_mux_sel = state == ACC2 || (state == DONE && is_ind);
    ind_load         = state == IND;
    done             = state == DONE;
    trap_pc_load     = state == DONE && op == OP_TRAP;
    newpcmux_sel     = trap_pc_load ? 2'b10 : 2'b00;
    stall            = state == ACC1 || state == IND || state == ACC2 || (state == IDLE && is_mem);
    dmem_byte_enable = !dmem_write ? 16'h0000 :
                       (state == ACC1 && op == OP_STB) ? 16'h0001 << addr_lo :
                       16'h0003 << {addr_lo[3:1], 1'b0};
  end
endmodule
